// File: rtl/wishbone_master_pkg.sv
// Shared definitions for the Wishbone initiator: FSM states and slave register addresses.
// The slave bench uses the same address constants.
package wishbone_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic ADR_DATA = 1'b0;
    localparam logic ADR_CMD  = 1'b1;

endpackage

// File: rtl/wishbone_master_timeout_counter.sv
// Bounded-wait counter for the Wishbone initiator; flags the last permitted strobe cycle.
// Saturates at TIMEOUT so a stuck enable never wraps back into range.
module wb_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != MAX)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/wishbone_master.sv
// Wishbone initiator: one host request becomes one single-strobe Wishbone transfer and one
// response pulse; a missing ack is converted into an error response after TIMEOUT cycles.
module wishbone_master
    import wishbone_master_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic                  req_adr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_error,
    output logic                  we_o,
    output logic                  adr_o,
    output logic                  strobe_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic                  ack_i
);

    state_t                state, state_n;
    logic                  req_ready_n, strobe_n, we_n, adr_n;
    logic                  rsp_valid_n, rsp_error_n;
    logic [DATA_WIDTH-1:0] wb_data_n, rsp_data_n;
    logic                  cnt_clear, cnt_enable, expired;

    wb_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (expired)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            strobe_o  <= 1'b0;
            we_o      <= 1'b0;
            adr_o     <= 1'b0;
            wb_data_o <= '0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_n;
            req_ready <= req_ready_n;
            strobe_o  <= strobe_n;
            we_o      <= we_n;
            adr_o     <= adr_n;
            wb_data_o <= wb_data_n;
            rsp_valid <= rsp_valid_n;
            rsp_error <= rsp_error_n;
            rsp_data  <= rsp_data_n;
        end
    end

    // Next values for every registered output; anything not touched holds.
    always_comb begin
        state_n     = state;
        req_ready_n = req_ready;
        strobe_n    = strobe_o;
        we_n        = we_o;
        adr_n       = adr_o;
        wb_data_n   = wb_data_o;
        rsp_valid_n = 1'b0;
        rsp_error_n = rsp_error;
        rsp_data_n  = rsp_data;
        cnt_clear   = 1'b0;
        cnt_enable  = 1'b0;

        case (state)
            ST_IDLE: begin
                req_ready_n = 1'b1;
                strobe_n    = 1'b0;
                if (req_valid) begin
                    we_n        = req_we;
                    adr_n       = req_adr;
                    wb_data_n   = req_data;
                    cnt_clear   = 1'b1;
                    req_ready_n = 1'b0;
                    strobe_n    = 1'b1;
                    state_n     = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                cnt_enable = 1'b1;
                // Ack is checked first so an ack on the final permitted cycle still succeeds.
                if (ack_i) begin
                    rsp_data_n  = we_o ? '0 : wb_data_i;
                    rsp_error_n = 1'b0;
                    rsp_valid_n = 1'b1;
                    strobe_n    = 1'b0;
                    state_n     = ST_RESP;
                end else if (expired) begin
                    rsp_data_n  = '0;
                    rsp_error_n = 1'b1;
                    rsp_valid_n = 1'b1;
                    strobe_n    = 1'b0;
                    state_n     = ST_RESP;
                end
            end
            ST_RESP: begin
                req_ready_n = 1'b1;
                strobe_n    = 1'b0;
                state_n     = ST_IDLE;
            end
            default: begin
                req_ready_n = 1'b1;
                strobe_n    = 1'b0;
                state_n     = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wishbone_master.sv
// Directed bench for wishbone_master: inputs driven and outputs sampled on the falling edge.
module tb_wishbone_master;

    localparam int unsigned DW = 64;
    localparam int unsigned TO = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_we, req_adr;
    logic [DW-1:0] req_data;
    logic          rsp_valid, rsp_error;
    logic [DW-1:0] rsp_data;
    logic          we_o, adr_o, strobe_o;
    logic [DW-1:0] wb_data_o, wb_data_i;
    logic          ack_i;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    wishbone_master #(
        .DATA_WIDTH(DW),
        .TIMEOUT(TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_error (rsp_error),
        .we_o      (we_o),
        .adr_o     (adr_o),
        .strobe_o  (strobe_o),
        .wb_data_o (wb_data_o),
        .wb_data_i (wb_data_i),
        .ack_i     (ack_i)
    );

    // Issues one request; the slave acks on strobe cycle ack_at (0 = never acks).
    task automatic do_txn(input logic we, input logic adr, input logic [DW-1:0] data,
                          input int ack_at, input logic [DW-1:0] rdata,
                          output int slen, output int nrsp, output logic err,
                          output logic [DW-1:0] rd, output logic cap_we, output logic cap_adr,
                          output logic [DW-1:0] cap_data, output logic cap_ready,
                          output logic stable, output logic done);
        slen = 0; nrsp = 0; err = 1'b0; rd = '0; stable = 1'b1; done = 1'b0;
        cap_we = 1'b0; cap_adr = 1'b0; cap_data = '0; cap_ready = 1'b1;
        @(negedge clock);
        req_valid = 1'b1; req_we = we; req_adr = adr; req_data = data;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        req_data  = ~data;
        for (int i = 0; i < 64; i++) begin
            if (strobe_o) begin
                slen++;
                if (slen == 1) begin
                    cap_we = we_o; cap_adr = adr_o; cap_data = wb_data_o; cap_ready = req_ready;
                end else if (we_o !== cap_we || adr_o !== cap_adr || wb_data_o !== cap_data) begin
                    stable = 1'b0;
                end
            end
            if (rsp_valid) begin
                nrsp++;
                err = rsp_error;
                rd  = rsp_data;
            end
            if (nrsp > 0 && !rsp_valid && req_ready && !strobe_o) begin
                done = 1'b1;
                break;
            end
            ack_i     = (ack_at != 0) && strobe_o && (slen == ack_at);
            wb_data_i = ack_i ? rdata : 64'h5A5A_5A5A_5A5A_5A5A;
            @(negedge clock);
        end
        ack_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({req_ready, strobe_o, we_o, adr_o, rsp_valid, rsp_error} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=100000",
                     {req_ready, strobe_o, we_o, adr_o, rsp_valid, rsp_error});
        end
        checks++;
        if (wb_data_o !== '0 || rsp_data !== '0) begin
            failures++;
            $display("FAIL reset_data wb_data_o=%h rsp_data=%h want 0", wb_data_o, rsp_data);
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_read_cmd();
        int slen, nrsp; logic err, cwe, cadr, crdy, stab, done; logic [DW-1:0] rd, cdat;
        do_txn(1'b0, 1'b1, 64'h1234, 2, 64'h0000_0000_0000_00A5,
               slen, nrsp, err, rd, cwe, cadr, cdat, crdy, stab, done);
        checks++;
        if (!done) begin failures++; $display("FAIL read_done got=0 want=1"); end
        checks++;
        if (cwe !== 1'b0 || cadr !== 1'b1 || crdy !== 1'b0) begin
            failures++; $display("FAIL read_bus we=%b adr=%b ready=%b want 0 1 0", cwe, cadr, crdy);
        end
        checks++;
        if (slen != 2) begin failures++; $display("FAIL read_strobe_len got=%0d want=2", slen); end
        checks++;
        if (nrsp != 1 || err !== 1'b0 || rd !== 64'hA5) begin
            failures++; $display("FAIL read_rsp n=%0d err=%b data=%h want 1 0 a5", nrsp, err, rd);
        end
    endtask

    task automatic test_write_data();
        int slen, nrsp; logic err, cwe, cadr, crdy, stab, done; logic [DW-1:0] rd, cdat;
        do_txn(1'b1, 1'b0, 64'hDEAD_BEEF_0123_4567, 2, 64'hFFFF_FFFF_FFFF_FFFF,
               slen, nrsp, err, rd, cwe, cadr, cdat, crdy, stab, done);
        checks++;
        if (cwe !== 1'b1 || cadr !== 1'b0 || cdat !== 64'hDEAD_BEEF_0123_4567) begin
            failures++; $display("FAIL write_bus we=%b adr=%b data=%h want 1 0 deadbeef01234567", cwe, cadr, cdat);
        end
        checks++;
        if (!stab) begin failures++; $display("FAIL write_stable got=changed want=held"); end
        checks++;
        if (!done || nrsp != 1 || err !== 1'b0 || rd !== '0) begin
            failures++; $display("FAIL write_rsp done=%b n=%0d err=%b data=%h want 1 1 0 0", done, nrsp, err, rd);
        end
    endtask

    task automatic test_ack_last();
        int slen, nrsp; logic err, cwe, cadr, crdy, stab, done; logic [DW-1:0] rd, cdat;
        do_txn(1'b0, 1'b0, '0, TO, 64'h1122_3344_5566_7788,
               slen, nrsp, err, rd, cwe, cadr, cdat, crdy, stab, done);
        checks++;
        if (slen != TO) begin failures++; $display("FAIL acklast_strobe_len got=%0d want=%0d", slen, TO); end
        checks++;
        if (!done || nrsp != 1 || err !== 1'b0 || rd !== 64'h1122_3344_5566_7788) begin
            failures++; $display("FAIL acklast_rsp n=%0d err=%b data=%h want 1 0 1122334455667788", nrsp, err, rd);
        end
    endtask

    task automatic test_timeout();
        int slen, nrsp, late; logic err, cwe, cadr, crdy, stab, done; logic [DW-1:0] rd, cdat;
        do_txn(1'b0, 1'b1, '0, 0, '0, slen, nrsp, err, rd, cwe, cadr, cdat, crdy, stab, done);
        checks++;
        if (slen != TO) begin failures++; $display("FAIL timeout_strobe_len got=%0d want=%0d", slen, TO); end
        checks++;
        if (!done || nrsp != 1 || err !== 1'b1 || rd !== '0) begin
            failures++; $display("FAIL timeout_rsp n=%0d err=%b data=%h want 1 1 0", nrsp, err, rd);
        end
        ack_i = 1'b1;
        wb_data_i = 64'hCAFE;
        late = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            ack_i = 1'b0;
            if (rsp_valid || strobe_o) late++;
        end
        checks++;
        if (late != 0 || rsp_error !== 1'b1 || rsp_data !== '0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL late_ack events=%0d err=%b data=%h ready=%b want 0 1 0 1", late, rsp_error, rsp_data, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        int rise[2]; int nr, nrsp, lowcnt; logic prev; logic [DW-1:0] d[2];
        nr = 0; nrsp = 0; lowcnt = 0; prev = 1'b0;
        rise[0] = 0; rise[1] = 0; d[0] = '0; d[1] = '0;
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b1; req_adr = 1'b0; req_data = 64'hAAAA_0000_0000_0001;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (strobe_o && !prev && nr < 2) begin
                rise[nr] = i; d[nr] = wb_data_o; nr++;
                if (nr == 1) req_data = 64'hBBBB_0000_0000_0002;
                if (nr == 2) req_valid = 1'b0;
            end
            if (nr == 1 && !strobe_o) lowcnt++;
            if (rsp_valid) nrsp++;
            ack_i = strobe_o;
            prev  = strobe_o;
        end
        ack_i = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (nr != 2 || rise[1] - rise[0] < 3 || lowcnt < 1) begin
            failures++;
            $display("FAIL b2b_spacing strobes=%0d spacing=%0d low=%0d want 2 >=3 >=1", nr, rise[1] - rise[0], lowcnt);
        end
        checks++;
        if (d[0] !== 64'hAAAA_0000_0000_0001 || d[1] !== 64'hBBBB_0000_0000_0002 || nrsp != 2) begin
            failures++; $display("FAIL b2b_data d0=%h d1=%h rsp=%0d want aaaa..01 bbbb..02 2", d[0], d[1], nrsp);
        end
    endtask

    task automatic test_reset_mid();
        int slen, nrsp, stray; logic err, cwe, cadr, crdy, stab, done; logic [DW-1:0] rd, cdat;
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b0; req_adr = 1'b1; req_data = 64'h77;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (strobe_o !== 1'b1) begin failures++; $display("FAIL mid_active strobe=%b want=1", strobe_o); end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({strobe_o, req_ready, rsp_valid, adr_o} !== 4'b0100) begin
            failures++; $display("FAIL mid_reset got=%b want=0100", {strobe_o, req_ready, rsp_valid, adr_o});
        end
        reset = 1'b1;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (rsp_valid || strobe_o) stray++;
        end
        checks++;
        if (stray != 0) begin failures++; $display("FAIL mid_no_rsp events=%0d want=0", stray); end
        do_txn(1'b0, 1'b0, '0, 3, 64'h0BAD_F00D_0000_0042,
               slen, nrsp, err, rd, cwe, cadr, cdat, crdy, stab, done);
        checks++;
        if (!done || slen != 3 || nrsp != 1 || err !== 1'b0 || rd !== 64'h0BAD_F00D_0000_0042) begin
            failures++;
            $display("FAIL mid_recover done=%b len=%0d n=%0d err=%b data=%h want 1 3 1 0 0badf00d00000042",
                     done, slen, nrsp, err, rd);
        end
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = 1'b0;
        req_data = '0; wb_data_i = '0; ack_i = 1'b0;
        test_reset();
        test_read_cmd();
        test_write_data();
        test_ack_last();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
